// File: rtl/seq_checker_pkg.sv
// Shared constants for the sequence checker: the legal counter cycle,
// tracker states and the position-advance helper.
package seq_checker_pkg;

    localparam int SEQ_LEN = 10;

    localparam logic [3:0] SEQ [0:SEQ_LEN-1] = '{
        4'd8, 4'd2, 4'd11, 4'd7, 4'd14,
        4'd1, 4'd4, 4'd8,  4'd4, 4'd15
    };

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    function automatic logic [3:0] next_idx(input logic [3:0] i);
        return (i == 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1;
    endfunction

endpackage

// File: rtl/seq_checker_lut.sv
// Combinational lookups: adjacent-pair to position, and position to
// sequence value.
module seq_checker_lut
    import seq_checker_pkg::*;
(
    input  logic [3:0] i_prev,
    input  logic [3:0] i_d,
    input  logic [3:0] i_idx,
    output logic       o_pair_ok,
    output logic [3:0] o_pair_idx,
    output logic [3:0] o_seq_val
);

    // A pair is legal when i_prev sits just before i_d in the cycle;
    // pairs are unique, so at most one k matches.
    always_comb begin
        o_pair_ok  = 1'b0;
        o_pair_idx = 4'd0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            if (SEQ[(k + SEQ_LEN - 1) % SEQ_LEN] == i_prev &&
                SEQ[k] == i_d) begin
                o_pair_ok  = 1'b1;
                o_pair_idx = 4'(k);
            end
        end
    end

    always_comb begin
        o_seq_val = 4'd0;
        if (i_idx < 4'(SEQ_LEN)) o_seq_val = SEQ[i_idx];
    end

endmodule

// File: rtl/seq_checker.sv
// Flywheel monitor for the arbitrary-sequence counter output.
// Optional SEQ_CHECKER_STICKY_EN adds err_sticky and freezes periods after it.
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8,
    parameter int PER_W      = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic [3:0]       D,
    output logic             locked,
    output logic [3:0]       pos,
    output logic [3:0]       expected,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
`ifdef SEQ_CHECKER_STICKY_EN
    output logic             err_sticky,
`endif
    output logic [PER_W-1:0] periods
);

    localparam logic [ERR_W-1:0] ERR_ONE = 1;
    localparam logic [PER_W-1:0] PER_ONE = 1;

    state_t           r_state;
    logic [3:0]       r_prev;
    logic             r_prev_valid;
    logic [3:0]       r_miss;
    logic             r_locked;
    logic [3:0]       r_pos;
    logic [3:0]       r_expected;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [PER_W-1:0] r_periods;

    logic       w_pair_ok;
    logic [3:0] w_pair_idx;
    logic [3:0] w_lut_idx;
    logic [3:0] w_seq_val;
    logic [3:0] w_pos_nx;
    logic [3:0] w_miss_nx;
    logic       w_mismatch;
    logic       w_lose;
    logic       w_per_en;

    assign w_pos_nx   = next_idx(r_pos);
    assign w_miss_nx  = r_miss + 4'd1;
    assign w_mismatch = (D != r_expected);
    assign w_lose     = w_mismatch && (w_miss_nx >= 4'(MISS_LIMIT));
    // One LUT port serves both the lock target and the flywheel lookahead.
    assign w_lut_idx  = (r_state == LOCKED) ? next_idx(w_pos_nx)
                                            : next_idx(w_pair_idx);

    seq_checker_lut u_lut (
        .i_prev     (r_prev),
        .i_d        (D),
        .i_idx      (w_lut_idx),
        .o_pair_ok  (w_pair_ok),
        .o_pair_idx (w_pair_idx),
        .o_seq_val  (w_seq_val)
    );

`ifdef SEQ_CHECKER_STICKY_EN
    logic r_sticky;
    assign w_per_en   = !r_sticky;
    assign err_sticky = r_sticky;

    always_ff @(posedge C or posedge R) begin
        if (R) r_sticky <= 1'b0;
        else if (r_state == LOCKED && w_mismatch) r_sticky <= 1'b1;
    end
`else
    assign w_per_en = 1'b1;
`endif

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state      <= SEARCH;
            r_prev       <= 4'd0;
            r_prev_valid <= 1'b0;
            r_miss       <= 4'd0;
            r_locked     <= 1'b0;
            r_pos        <= 4'd0;
            r_expected   <= 4'd0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_periods    <= '0;
        end else begin
            r_prev       <= D;
            r_prev_valid <= 1'b1;
            unique case (r_state)
                SEARCH: begin
                    r_err <= 1'b0;
                    if (r_prev_valid && w_pair_ok) begin
                        r_state    <= LOCKED;
                        r_locked   <= 1'b1;
                        r_pos      <= w_pair_idx;
                        r_expected <= w_seq_val;
                        r_miss     <= 4'd0;
                    end
                end
                LOCKED: begin
                    r_err <= w_mismatch;
                    if (w_mismatch && r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + ERR_ONE;
                    if (r_pos == 4'(SEQ_LEN - 1) && w_per_en)
                        r_periods <= r_periods + PER_ONE;
                    if (w_lose) begin
                        r_state    <= SEARCH;
                        r_locked   <= 1'b0;
                        r_pos      <= 4'd0;
                        r_expected <= 4'd0;
                        r_miss     <= 4'd0;
                    end else begin
                        r_pos      <= w_pos_nx;
                        r_expected <= w_seq_val;
                        r_miss     <= w_mismatch ? w_miss_nx : 4'd0;
                    end
                end
            endcase
        end
    end

    assign locked   = r_locked;
    assign pos      = r_pos;
    assign expected = r_expected;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign periods  = r_periods;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_seq_checker;

`ifdef SEQ_CHECKER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic [3:0] D = 4'd0;

    logic       locked, err;
    logic [3:0] pos, expected;
    logic [7:0] err_cnt, periods;

    logic       s_locked, s_err;
    logic [3:0] s_pos, s_expected;
    logic [1:0] s_err_cnt;
    logic [7:0] s_periods;

`ifdef SEQ_CHECKER_STICKY_EN
    logic err_sticky, s_err_sticky;
`endif

    seq_checker #(.MISS_LIMIT(2), .ERR_W(8), .PER_W(8)) u_dut (
        .C(C), .R(R), .D(D),
        .locked(locked), .pos(pos), .expected(expected),
        .err(err), .err_cnt(err_cnt),
`ifdef SEQ_CHECKER_STICKY_EN
        .err_sticky(err_sticky),
`endif
        .periods(periods)
    );

    seq_checker #(.MISS_LIMIT(15), .ERR_W(2), .PER_W(8)) u_sat (
        .C(C), .R(R), .D(D),
        .locked(s_locked), .pos(s_pos), .expected(s_expected),
        .err(s_err), .err_cnt(s_err_cnt),
`ifdef SEQ_CHECKER_STICKY_EN
        .err_sticky(s_err_sticky),
`endif
        .periods(s_periods)
    );

    always #5 C = ~C;

    int n_cmp = 0;
    int n_bad = 0;

    int ref_seq [10] = '{8, 2, 11, 7, 14, 1, 4, 8, 4, 15};

    // Behavioural model state (plain integers)
    int m_locked, m_pos, m_exp, m_err, m_cnt, m_per;
    int m_miss, m_prev, m_pv, m_sticky;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_exp = 0; m_err = 0; m_cnt = 0;
        m_per = 0; m_miss = 0; m_prev = 0; m_pv = 0; m_sticky = 0;
    endtask

    function automatic int find_pair(input int p, input int d);
        for (int i = 0; i < 10; i++)
            if (ref_seq[(i + 9) % 10] == p && ref_seq[i] == d) return i;
        return -1;
    endfunction

    task automatic model_edge(input int d);
        int idx, np;
        if (m_locked == 0) begin
            m_err = 0;
            idx = find_pair(m_prev, d);
            if (m_pv == 1 && idx >= 0) begin
                m_locked = 1;
                m_pos = idx;
                m_exp = ref_seq[(idx + 1) % 10];
                m_miss = 0;
            end
        end else begin
            np = (m_pos + 1) % 10;
            m_err = (d != m_exp) ? 1 : 0;
            if (m_pos == 9 && !(STICKY && m_sticky == 1))
                m_per = (m_per + 1) % 256;
            if (m_err == 1) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_miss++;
                m_sticky = 1;
            end else begin
                m_miss = 0;
            end
            if (m_miss >= 2) begin
                m_locked = 0; m_pos = 0; m_exp = 0; m_miss = 0;
            end else begin
                m_pos = np;
                m_exp = ref_seq[(np + 1) % 10];
            end
        end
        m_prev = d;
        m_pv = 1;
    endtask

    task automatic compare_model();
        check("locked", int'(locked), m_locked);
        check("pos", int'(pos), m_pos);
        check("expected", int'(expected), m_exp);
        check("err", int'(err), m_err);
        check("err_cnt", int'(err_cnt), m_cnt);
        check("periods", int'(periods), m_per);
`ifdef SEQ_CHECKER_STICKY_EN
        check("err_sticky", int'(err_sticky), m_sticky);
`endif
    endtask

    task automatic step(input int d);
        @(negedge C);
        D = 4'(d);
        @(posedge C);
        model_edge(d);
        #1;
        compare_model();
    endtask

    task automatic do_reset(input string tag);
        @(negedge C);
        #2;
        R = 1'b1;
        #1;
        model_reset();
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_pos"}, int'(pos), 0);
        check({tag, "_expected"}, int'(expected), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_periods"}, int'(periods), 0);
        check({tag, "_sat_cnt"}, int'(s_err_cnt), 0);
        @(negedge C);
        R = 1'b0;
    endtask

    typedef struct {
        int d;
        int lk;
        int p;
        int e;
        int er;
        int cnt;
        int per;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int g, r, d;
        tbl[0]  = '{8,  0, 0, 0,  0, 0, 0};
        tbl[1]  = '{2,  1, 1, 11, 0, 0, 0};
        tbl[2]  = '{11, 1, 2, 7,  0, 0, 0};
        tbl[3]  = '{6,  1, 3, 14, 1, 1, 0};
        tbl[4]  = '{14, 1, 4, 1,  0, 1, 0};
        tbl[5]  = '{1,  1, 5, 4,  0, 1, 0};
        tbl[6]  = '{4,  1, 6, 8,  0, 1, 0};
        tbl[7]  = '{8,  1, 7, 4,  0, 1, 0};
        tbl[8]  = '{4,  1, 8, 15, 0, 1, 0};
        tbl[9]  = '{15, 1, 9, 8,  0, 1, 0};
        tbl[10] = '{8,  1, 0, 2,  0, 1, STICKY ? 0 : 1};

        model_reset();
        R = 1'b1;
        #12;
        do_reset("rst0");

        // Lock from the start, one substituted sample, full wrap
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].d);
            check($sformatf("tbl%0d_locked", i), int'(locked), tbl[i].lk);
            check($sformatf("tbl%0d_pos", i), int'(pos), tbl[i].p);
            check($sformatf("tbl%0d_exp", i), int'(expected), tbl[i].e);
            check($sformatf("tbl%0d_err", i), int'(err), tbl[i].er);
            check($sformatf("tbl%0d_cnt", i), int'(err_cnt), tbl[i].cnt);
            check($sformatf("tbl%0d_per", i), int'(periods), tbl[i].per);
        end

        // Clean run: 30 cycles with no error
        do_reset("rst1");
        g = 0;
        for (int i = 0; i < 30; i++) begin
            step(ref_seq[g]);
            g = (g + 1) % 10;
            if (i >= 1) check("clean_err", int'(err), 0);
        end
        check("clean_locked", int'(locked), 1);

        // Mid-cycle lock on 4,15, wrap, then lock loss and re-lock
        do_reset("rst2");
        step(4);
        step(15);
        check("mid_locked", int'(locked), 1);
        check("mid_pos", int'(pos), 9);
        check("mid_exp", int'(expected), 8);
        step(8);
        check("wrap_pos", int'(pos), 0);
        check("wrap_per", int'(periods), 1);
        step(2);
        step(6);
        check("miss1_err", int'(err), 1);
        check("miss1_locked", int'(locked), 1);
        step(6);
        check("miss2_err", int'(err), 1);
        check("miss2_cnt", int'(err_cnt), 2);
        check("miss2_locked", int'(locked), 0);
        step(8);
        check("relock_wait", int'(locked), 0);
        step(2);
        check("relock_locked", int'(locked), 1);
        check("relock_pos", int'(pos), 1);

        // Asynchronous reset while locked
        do_reset("rst_mid");

        // Patterns that never form a legal pair
        for (int i = 0; i < 4; i++) begin
            step(2);
            step(8);
            step(0);
            check("nolock_locked", int'(locked), 0);
        end
        for (int i = 0; i < 10; i++) step(0);
        check("nolock_final", int'(locked), 0);
        check("nolock_cnt", int'(err_cnt), 0);

        // Saturation on the 2-bit counter instance
        do_reset("rst3");
        step(8);
        step(2);
        for (int i = 0; i < 5; i++) step(0);
        check("sat_cnt", int'(s_err_cnt), 3);
        check("sat_locked", int'(s_locked), 1);
        check("sat_main_locked", int'(locked), 0);
        for (int i = 0; i < 11; i++) step(tbl[i].d == 6 ? 7 : tbl[i].d);
        check("per_after_err", int'(periods), STICKY ? 0 : 1);
`ifdef SEQ_CHECKER_STICKY_EN
        check("sticky_set", int'(err_sticky), 1);
`endif

        // Randomized traffic: mostly legal with substitutions and jumps
        do_reset("rst4");
        g = 0;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) begin
                d = ref_seq[g];
                g = (g + 1) % 10;
            end else if (r < 93) begin
                d = int'($urandom_range(0, 15));
                g = (g + 1) % 10;
            end else begin
                g = int'($urandom_range(0, 9));
                d = ref_seq[g];
                g = (g + 1) % 10;
            end
            step(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Downstream monitor for the arbitrary-sequence counter; samples its 4-bit output every clock.
- Legal cycle is 8 2 11 7 14 1 4 8 4 15, then wraps to 8; positions are indexed 0..9.
- Acquires lock on the sequence, then tracks the position with a flywheel and flags deviations.
- Reports position, next expected value, error pulses/counts and completed periods to test/debug logic.

Parameters:
- MISS_LIMIT, 2, consecutive mismatches while locked that force loss of lock (range 1..15).
- ERR_W, 8, width of the saturating error counter.
- PER_W, 8, width of the completed-period counter; wraps modulo 2^PER_W.

Ports:
- C  input  1  clock; all state updates on posedge C.
- R  input  1  reset, asynchronous, active-high.
- D  input  4  counter output value, sampled every posedge C.
- locked  output  1  tracker is locked to the sequence.
- pos  output  4  index 0..9 of the last sampled D; 0 when not locked.
- expected  output  4  sequence value predicted for the next sample; 0 when not locked.
- err  output  1  one-cycle pulse for a mismatch while locked.
- err_cnt  output  ERR_W  total mismatches, saturating at all-ones.
- periods  output  PER_W  count of locked 9->0 position wraps.

Behaviour:
- All outputs and state are registered. R forces immediately: state SEARCH, locked=0, pos=0, expected=0, err=0, err_cnt=0, periods=0, miss=0, prev_valid=0.
- Internal state: a registered previous sample (prev, prev_valid) and a miss counter.
- Values 8 and 4 each occur twice in the cycle, so one sample is ambiguous. Lock is based on the pair (prev, D):
  - (8,2) gives index 1; (8,4) gives index 8.
  - (4,8) gives index 7; (4,15) gives index 9.
  - (15,8) gives index 0.
  - Every other adjacent pair maps uniquely.
- SEARCH:
  - Every cycle: prev<=D, prev_valid<=1.
  - If prev_valid and (prev,D) is a legal adjacent pair: move to LOCKED, pos<=index of D, expected<=SEQ[(pos+1) mod 10], miss<=0.
  - locked rises on the edge after the second matching sample (lock latency is 2 samples from reset).
  - Values 0,3,5,6,9,10,12,13 and illegal pairs keep SEARCH.
  - err never pulses in SEARCH.
- LOCKED, on each edge:
  - pos always advances mod 10 (flywheel); expected is updated to match.
  - D==expected: miss<=0, err<=0.
  - D!=expected: err<=1 for one cycle, err_cnt increments (saturating), miss increments.
  - When pos goes 9->0, periods increments, whether or not that sample matched.
  - If miss reaches MISS_LIMIT: next state is SEARCH; locked, pos and expected go to 0; prev<=D and prev_valid<=1, so re-lock can occur on the very next sample.
- Simultaneous events: a mismatch that also causes lock loss still pulses err and still counts.
- R mid-operation discards lock and all counters.

Optional Feature:
- SEQ_CHECKER_STICKY_EN defined:
  - Extra output err_sticky (1 bit) sets on any err pulse and clears only on R.
  - While err_sticky=1, periods stops incrementing.
- Undefined: the port is absent and periods is unaffected.

Decomposition:
- Package seq_checker_pkg holds:
  - SEQ_LEN=10.
  - Sequence constant array SEQ[0:9].
  - State enum {SEARCH, LOCKED}.
  - Function next_idx(i).
- One sub-module, seq_checker_lut, purely combinational:
  - Maps (prev, D) to {pair_ok, idx}.
  - Maps idx to SEQ value.

Test Plan:
- Reset, then drive 8,2,11,7,... every cycle: locked=1 after the 2nd edge with pos=1, expected=11; err stays 0 for 30 cycles.
- Start mid-cycle with 4,15: lock with pos=9, expected=8; the next sample 8 gives pos=0 and periods=1.
- While locked, replace 7 with 6 once: err pulses 1 cycle, err_cnt=1, locked stays 1; the following 14 matches with pos=4.
- While locked, drive 6,6 (MISS_LIMIT=2): err pulses twice, err_cnt=2, locked falls; then 8,2 re-locks with pos=1.
- Drive a 2,8 repeat pattern, then constant 0: locked never rises and err_cnt stays 0. Assert R mid-lock: every output is 0 immediately.
- ERR_W=2 with 5 forced mismatches (MISS_LIMIT=15): err_cnt saturates at 3. With SEQ_CHECKER_STICKY_EN: err_sticky=1 and periods frozen.
